// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multicycle MIPS lab CPU.
// Sequences the shared memory port, ALU and IR/MDR/A/B/ALUOut registers one
// state per cycle, counts retired instructions and flags illegal opcodes.
// Optional build macro MULTICYCLE_MEM_WAIT_EN adds mem_ready_i so that FETCH,
// MEM_RD and MEM_WR stall until memory signals completion.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
`ifdef MULTICYCLE_MEM_WAIT_EN
    input  logic             mem_ready_i,
`endif
    input  logic [5:0]       opcode_i,
    input  logic [5:0]       funct_i,
    input  logic             zero_i,
    output logic             pc_en_o,
    output logic             iord_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             ir_write_o,
    output logic [1:0]       reg_dst_o,
    output logic [1:0]       mem_to_reg_o,
    output logic             reg_write_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic [1:0]       pc_src_o,
    output logic             instr_done_o,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic             illegal_o,
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        I_EXEC   = 4'd10,
        I_WB     = 4'd11,
        JAL      = 4'd12,
        JR       = 4'd13,
        HALT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             illegal_reg;
    logic             mem_ok;

    // Raw (pre-reset-gating) control values produced by the decoder.
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write;
    logic       alu_src_a, done;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_ok = mem_ready_i;
`else
    assign mem_ok = 1'b1;
`endif

    // State register, retired-instruction counter and sticky illegal flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= FETCH;
            cnt_reg     <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (done)
                cnt_reg <= cnt_reg + CNT_W'(1);
            // Raised on the edge entering HALT so it is visible for the whole stay.
            if (state_next == HALT)
                illegal_reg <= 1'b1;
        end
    end

    // Next-state decode and Moore control outputs (pc_en also depends on zero_i in BRANCH).
    always_comb begin
        state_next = state_reg;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        done       = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        case (state_reg)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_en     = mem_ok;
                ir_write  = mem_ok;
                if (mem_ok)
                    state_next = DECODE;
            end
            DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alu_src_b = 2'b11;
                case (opcode_i)
                    OP_RTYPE:       state_next = (funct_i == FN_JR) ? JR : R_EXEC;
                    OP_LW, OP_SW:   state_next = MEM_ADDR;
                    OP_BEQ, OP_BNE: state_next = BRANCH;
                    OP_ADDI, OP_SLTI: state_next = I_EXEC;
                    OP_J:           state_next = JUMP;
                    OP_JAL:         state_next = JAL;
                    default:        state_next = HALT;
                endcase
            end
            MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (opcode_i == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ok)
                    state_next = MEM_WB;
            end
            MEM_WB: begin
                mem_to_reg = 2'b01;
                reg_write  = 1'b1;
                done       = 1'b1;
                state_next = FETCH;
            end
            MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                done      = mem_ok;
                if (mem_ok)
                    state_next = FETCH;
            end
            R_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = R_WB;
            end
            R_WB: begin
                reg_dst    = 2'b01;
                reg_write  = 1'b1;
                done       = 1'b1;
                state_next = FETCH;
            end
            I_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = 2'b11;
                state_next = I_WB;
            end
            I_WB: begin
                reg_write  = 1'b1;
                done       = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                pc_en      = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
                done       = 1'b1;
                state_next = FETCH;
            end
            JUMP: begin
                pc_src     = 2'b10;
                pc_en      = 1'b1;
                done       = 1'b1;
                state_next = FETCH;
            end
            JAL: begin
                // PC already holds PC+4 from FETCH, so $31 gets the return address.
                pc_src     = 2'b10;
                pc_en      = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                reg_write  = 1'b1;
                done       = 1'b1;
                state_next = FETCH;
            end
            JR: begin
                pc_src     = 2'b11;
                pc_en      = 1'b1;
                done       = 1'b1;
                state_next = FETCH;
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Every output is held at zero while reset is asserted.
    assign pc_en_o      = pc_en & ~rst_i;
    assign iord_o       = iord & ~rst_i;
    assign mem_read_o   = mem_read & ~rst_i;
    assign mem_write_o  = mem_write & ~rst_i;
    assign ir_write_o   = ir_write & ~rst_i;
    assign reg_write_o  = reg_write & ~rst_i;
    assign alu_src_a_o  = alu_src_a & ~rst_i;
    assign instr_done_o = done & ~rst_i;
    assign reg_dst_o    = rst_i ? 2'b00 : reg_dst;
    assign mem_to_reg_o = rst_i ? 2'b00 : mem_to_reg;
    assign alu_src_b_o  = rst_i ? 2'b00 : alu_src_b;
    assign alu_op_o     = rst_i ? 2'b00 : alu_op;
    assign pc_src_o     = rst_i ? 2'b00 : pc_src;
    assign instr_cnt_o  = rst_i ? '0 : cnt_reg;
    assign illegal_o    = illegal_reg & ~rst_i;
    assign state_o      = rst_i ? 4'd0 : state_reg;

endmodule
